sumador_arbiter: RTL
====================

SUMADOR_ARBITER -- requirements
Module: sumador_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports named clk and rst.
REQ-002 The block SHALL have parameter WIDTH, default 8, giving the operand and result width in bits.
REQ-003 The block SHALL have port clk, input, 1 bit: rising-edge clock for all state.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous reset, active high.
REQ-005 The block SHALL have port req0, input, 1 bit: requester 0 has an operation pending.
REQ-006 The block SHALL have ports a0 and b0, input, WIDTH bits each: requester 0 operands.
REQ-007 The block SHALL have port gnt0, output, 1 bit: requester 0 operands are accepted this cycle.
REQ-008 The block SHALL have ports req1, a1, b1 and gnt1, with the same directions, widths and meanings as for requester 0.
REQ-009 The block SHALL have port res_valid, output, 1 bit: a result is presented.
REQ-010 The block SHALL have port res_ready, input, 1 bit: the consumer accepts the result.
REQ-011 The block SHALL have port res_data, output, WIDTH bits: the sum.
REQ-012 The block SHALL have port res_carry, output, 1 bit: the unsigned sum overflowed WIDTH bits.
REQ-013 The block SHALL have port res_id, output, 1 bit: the index of the requester that owns the result.

Function
REQ-014 The FSM SHALL have three states, IDLE, ADD and RESP; each state transition SHALL take exactly one clk edge.
REQ-015 In IDLE, when req0 or req1 is high, the block SHALL assert exactly one gnt combinationally and capture that requester's operands and id at the clock edge; the FSM SHALL then move to ADD.
REQ-016 In IDLE with no req, the FSM SHALL stay in IDLE, and gnt0 and gnt1 SHALL both be 0.
REQ-017 Arbitration SHALL be round-robin: when both reqs are high, the block SHALL grant the requester that is not recorded in the last_id register.
REQ-018 When exactly one req is high, the block SHALL grant that requester regardless of last_id.
REQ-019 last_id SHALL update to the granted index at the accepting edge.
REQ-020 In ADD, the block SHALL compute the sum of the captured operands as a (WIDTH+1)-bit value, register res_data and res_carry, and move to RESP.
REQ-021 In RESP, res_valid SHALL be 1, and res_data, res_carry and res_id SHALL stay stable until the cycle in which res_valid and res_ready are both high.
REQ-022 On the res_valid/res_ready handshake, the FSM SHALL return to IDLE; res_valid SHALL be 0 in the following cycle.
REQ-023 Latency from the grant edge to the first cycle of res_valid SHALL be 2 cycles.
REQ-024 Maximum throughput SHALL be one operation per 3 cycles.
REQ-025 The block SHALL NOT issue a gnt in the ADD or RESP states; reqs raised in those states SHALL wait.
REQ-026 A req dropped before it is granted SHALL be ignored without error.
REQ-027 res_carry SHALL be the bit WIDTH of the raw sum, in both configurations.
REQ-028 With wrap-around arithmetic, res_data SHALL be the sum mod 2^WIDTH; for example, 0xFF + 0x01 gives 0x00 with res_carry = 1.

Reset
REQ-029 When rst is high at a clock edge, the block SHALL set the state to IDLE, last_id to 1 (so requester 0 wins the first contention), and res_valid, res_data, res_carry and res_id to 0.
REQ-030 While rst is high, gnt0 and gnt1 SHALL be 0.
REQ-031 Reset in ADD or RESP SHALL abort the operation and discard the result, with no handshake issued.

Configuration
REQ-032 When macro SUMADOR_SAT_EN is defined, res_data SHALL saturate to 2^WIDTH-1 whenever the raw sum overflows (for example, 0xF0 + 0x20 gives 0xFF with res_carry = 1).
REQ-033 When SUMADOR_SAT_EN is not defined, the block SHALL use wrap-around arithmetic as in REQ-028; all other behaviour SHALL be identical in both configurations.

Structure
REQ-034 The shared package sumador_pkg SHALL hold the default WIDTH constant, the FSM state typedef (IDLE, ADD, RESP) and the requester-id typedef.
REQ-035 The adder and saturation logic SHALL be a sub-module, sumador_core, with inputs a and b and outputs sum and carry; the sub-module SHALL contain no state.

Verification
REQ-036 Reset then single request: apply rst for 2 cycles, then req0 = 1 with a0 = 0x12 and b0 = 0x34 and res_ready = 1 -> gnt0 is 1 for one cycle; 2 cycles later res_valid = 1, res_data = 0x46, res_carry = 0 and res_id = 0.
REQ-037 Contention: hold req0 and req1 high continuously with res_ready = 1 -> grants alternate 0, 1, 0, 1, with one grant every 3 cycles and gnt0 and gnt1 never high together.
REQ-038 Backpressure: hold res_ready = 0 for 5 cycles during RESP -> res_valid stays 1, result outputs do not change, and no gnt is issued; raising res_ready causes return to IDLE next cycle.
REQ-039 Overflow: a1 = 0xF0 and b1 = 0x20 -> res_carry = 1, with res_data = 0x10 without SUMADOR_SAT_EN and 0xFF with it.
REQ-040 Reset mid-operation: assert rst in ADD -> next cycle res_valid = 0 and the state is IDLE; the next contention is granted to requester 0.

Source files
------------

// File: rtl/sumador_pkg.sv
// Shared types and constants for the two-requester arbitrated adder.
package sumador_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef logic req_id_t;

endpackage

// File: rtl/sumador_core.sv
// Stateless adder producing a carry-out; saturates on overflow when SUMADOR_SAT_EN is defined.
module sumador_core
    import sumador_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    logic [WIDTH:0] raw;

    always_comb begin
        raw   = {1'b0, a} + {1'b0, b};
        carry = raw[WIDTH];
`ifdef SUMADOR_SAT_EN
        sum   = carry ? {WIDTH{1'b1}} : raw[WIDTH-1:0];
`else
        sum   = raw[WIDTH-1:0];
`endif
    end

endmodule

// File: rtl/sumador_arbiter.sv
// Round-robin arbiter in front of a shared adder: IDLE grants, ADD computes, RESP holds the result.
// Optional saturation via SUMADOR_SAT_EN (handled inside sumador_core).
module sumador_arbiter
    import sumador_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    output logic             gnt0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             gnt1,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_carry,
    output logic             res_id
);

    state_t           state, state_nxt;
    req_id_t          last_id, gnt_id;
    logic             grant;
    logic [WIDTH-1:0] op_a, op_b, sum;
    logic             carry;

    sumador_core #(.WIDTH(WIDTH)) u_core (
        .a     (op_a),
        .b     (op_b),
        .sum   (sum),
        .carry (carry)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req0 || req1)          state_nxt = ADD;
            ADD:                                state_nxt = RESP;
            RESP:    if (res_ready)             state_nxt = IDLE;
            default:                            state_nxt = IDLE;
        endcase
    end

    // Under contention the requester not served last wins; a lone requester always wins.
    always_comb begin
        grant     = !rst && (state == IDLE) && (req0 || req1);
        if (req0 && req1) gnt_id = ~last_id;
        else              gnt_id = req1;
        gnt0      = grant && (gnt_id == 1'b0);
        gnt1      = grant && (gnt_id == 1'b1);
        res_valid = (state == RESP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_id   <= 1'b1;
            op_a      <= '0;
            op_b      <= '0;
            res_data  <= '0;
            res_carry <= 1'b0;
            res_id    <= 1'b0;
        end else begin
            if (grant) begin
                op_a    <= gnt_id ? a1 : a0;
                op_b    <= gnt_id ? b1 : b0;
                res_id  <= gnt_id;
                last_id <= gnt_id;
            end
            if (state == ADD) begin
                res_data  <= sum;
                res_carry <= carry;
            end
        end
    end

endmodule
